grid_sync_ctrl: RTL and testbench

//  Grid-level run/finish/barrier controller for the N_PE CPU array; next generation of the grid's flat busy/finish glue.

---
 rtl/grid_sync_ctrl_if.sv | 36 +++
 rtl/grid_sync_ctrl.sv | 117 +++++++++++
 tb/tb_grid_sync_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/grid_sync_ctrl_if.sv
// Host/PE-facing signal bundle of the grid run/finish/barrier controller.
// master drives the stimulus side (host + PE array), slave is the controller.
interface grid_sync_ctrl_if #(
  parameter int N_PE = 16,
  parameter int CL_W = $clog2(N_PE) + 1,
  parameter int TO_W = 16
);
  logic            start_i;
  logic            abort_i;
  logic [N_PE-1:0] pe_en_i;
  logic [CL_W-1:0] cfg_cl_log2;
  logic [TO_W-1:0] cfg_timeout;
  logic [N_PE-1:0] trap_i;
  logic [N_PE-1:0] mem_op_i;
  logic [N_PE-1:0] grant_i;
  logic [N_PE-1:0] bar_req_i;
  logic [N_PE-1:0] busy_o;
  logic [N_PE-1:0] bar_rel_o;
  logic [N_PE-1:0] cl_done_o;
  logic            finish_o;
  logic            error_o;
  logic [1:0]      state_o;
  logic [31:0]     run_cycles_o;

  modport master (
    output start_i, abort_i, pe_en_i, cfg_cl_log2, cfg_timeout,
           trap_i, mem_op_i, grant_i, bar_req_i,
    input  busy_o, bar_rel_o, cl_done_o, finish_o, error_o, state_o, run_cycles_o
  );

  modport slave (
    input  start_i, abort_i, pe_en_i, cfg_cl_log2, cfg_timeout,
           trap_i, mem_op_i, grant_i, bar_req_i,
    output busy_o, bar_rel_o, cl_done_o, finish_o, error_o, state_o, run_cycles_o
  );
endinterface

// File: rtl/grid_sync_ctrl.sv
// Grid run/finish/barrier controller: stall vector, per-PE finish tracking,
// runtime-sized cluster barriers, run FSM with cycle counter and watchdog.
module grid_sync_ctrl #(
  parameter int N_PE = 16,
  parameter int CL_W = $clog2(N_PE) + 1,
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  grid_sync_ctrl_if.slave bus
);
  localparam int LOG2N = $clog2(N_PE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t          state_q;
  logic [N_PE-1:0] grant_q;
  logic [N_PE-1:0] active_q;
  logic [N_PE-1:0] done_q;
  logic [N_PE-1:0] hold_q;
  logic [N_PE-1:0] rel_q;
  logic [CL_W-1:0] cl_q;
  logic [TO_W-1:0] to_q;
  logic [TO_W-1:0] idle_cnt;
  logic [31:0]     run_cycles;

  logic [N_PE-1:0] arrived;
  logic [N_PE-1:0] fresh;
  logic [N_PE-1:0] all_arr;
  logic [N_PE-1:0] any_fresh;
  logic [N_PE-1:0] all_done;
  logic [N_PE-1:0] rel_nx;
  logic [N_PE-1:0] new_done;
  logic            all_fin;
  logic            do_start;
  logic [CL_W-1:0] cl_sel;

  // A PE trapping in the same cycle it requests counts as arrived but is never released.
  always_comb begin
    arrived   = ~active_q | done_q | (bus.bar_req_i & ~hold_q);
    fresh     = active_q & ~done_q & ~bus.trap_i & bus.bar_req_i & ~hold_q;
    all_arr   = '1;
    any_fresh = '0;
    all_done  = '1;
    for (int unsigned p = 0; p < N_PE; p++) begin
      for (int unsigned q = 0; q < N_PE; q++) begin
        if ((p >> cl_q) == (q >> cl_q)) begin
          all_arr[p]   = all_arr[p] & arrived[q];
          any_fresh[p] = any_fresh[p] | fresh[q];
          all_done[p]  = all_done[p] & (done_q[q] | ~active_q[q]);
        end
      end
    end
    rel_nx   = (state_q == RUN) ? (all_arr & any_fresh & fresh) : '0;
    new_done = active_q & bus.trap_i & ~done_q;
    all_fin  = &(done_q | ~active_q);
    do_start = bus.start_i & ~bus.abort_i & (state_q != RUN);
    cl_sel   = (bus.cfg_cl_log2 > CL_W'(LOG2N)) ? CL_W'(LOG2N) : bus.cfg_cl_log2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      active_q   <= '0;
      done_q     <= '0;
      hold_q     <= '0;
      rel_q      <= '0;
      cl_q       <= '0;
      to_q       <= '0;
      idle_cnt   <= '0;
      run_cycles <= '0;
    end else begin
      grant_q <= bus.grant_i;
      if (bus.abort_i) begin
        state_q <= IDLE;
        done_q  <= '0;
        hold_q  <= '0;
        rel_q   <= '0;
      end else if (do_start) begin
        state_q    <= (bus.pe_en_i == '0) ? DONE : RUN;
        active_q   <= bus.pe_en_i;
        cl_q       <= cl_sel;
        to_q       <= bus.cfg_timeout;
        done_q     <= '0;
        hold_q     <= '0;
        rel_q      <= '0;
        idle_cnt   <= '0;
        run_cycles <= '0;
      end else begin
        rel_q  <= rel_nx;
        hold_q <= (hold_q & bus.bar_req_i) | rel_nx;
        if (state_q == RUN) begin
          done_q <= done_q | (bus.trap_i & active_q);
          if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
          if ((new_done != '0) || (rel_nx != '0)) idle_cnt <= '0;
          else if (idle_cnt != '1) idle_cnt <= idle_cnt + TO_W'(1);
          if (all_fin) state_q <= DONE;
          else if ((to_q != '0) && (idle_cnt == to_q)) state_q <= ERR;
        end
      end
    end
  end

  assign bus.busy_o       = bus.mem_op_i & ~grant_q;
  assign bus.bar_rel_o    = rel_q;
  assign bus.cl_done_o    = ((state_q == RUN) || (state_q == DONE)) ? all_done : '0;
  assign bus.finish_o     = (state_q == DONE);
  assign bus.error_o      = (state_q == ERR);
  assign bus.state_o      = state_q;
  assign bus.run_cycles_o = run_cycles;
endmodule

// File: tb/tb_grid_sync_ctrl.sv
// Directed bench for grid_sync_ctrl: finish timing, cluster barriers, watchdog,
// stall vector, abort priority and async reset.
module tb_grid_sync_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  grid_sync_ctrl_if #(.N_PE(16), .CL_W(5), .TO_W(16)) bus ();

  grid_sync_ctrl #(.N_PE(16), .CL_W(5), .TO_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] pe, input logic [4:0] cl, input logic [15:0] to);
    bus.start_i     = 1'b1;
    bus.pe_en_i     = pe;
    bus.cfg_cl_log2 = cl;
    bus.cfg_timeout = to;
    tick();
    bus.start_i     = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start_i = 0; bus.abort_i = 0; bus.pe_en_i = '0; bus.cfg_cl_log2 = '0;
    bus.cfg_timeout = '0; bus.trap_i = '0; bus.mem_op_i = '0; bus.grant_i = '0;
    bus.bar_req_i = '0;
    tick(); tick();
    check_eq("rst_state", 32'(bus.state_o), 32'd0);
    check_eq("rst_finish", 32'(bus.finish_o), 32'd0);
    check_eq("rst_rel", 32'(bus.bar_rel_o), 32'd0);
    check_eq("rst_cycles", bus.run_cycles_o, 32'd0);
    rst = 1'b0;
    tick();

    // staggered traps, last sampled at E3 -> finish visible after E4
    start_run(16'hFFFF, 5'd2, 16'd0);
    check_eq("run_state", 32'(bus.state_o), 32'd1);
    check_eq("run_cycles0", bus.run_cycles_o, 32'd0);
    bus.trap_i = 16'h000F; tick();
    check_eq("cl_done_a", 32'(bus.cl_done_o), 32'h000F);
    bus.trap_i = 16'h00FF; tick();
    check_eq("cl_done_b", 32'(bus.cl_done_o), 32'h00FF);
    bus.trap_i = 16'hFFFF; tick();
    check_eq("finish_t1", 32'(bus.finish_o), 32'd0);
    check_eq("state_t1", 32'(bus.state_o), 32'd1);
    tick();
    check_eq("finish_t2", 32'(bus.finish_o), 32'd1);
    check_eq("state_done", 32'(bus.state_o), 32'd2);
    check_eq("run_cycles", bus.run_cycles_o, 32'd4);
    check_eq("cl_done_all", 32'(bus.cl_done_o), 32'hFFFF);
    tick();
    check_eq("finish_hold", 32'(bus.finish_o), 32'd1);
    check_eq("cycles_hold", bus.run_cycles_o, 32'd4);
    bus.trap_i = '0;
    do_abort();
    check_eq("abort_idle", 32'(bus.state_o), 32'd0);

    // cluster of 4: fires only when PE3 joins, then held request cannot re-fire
    start_run(16'hFFFF, 5'd2, 16'd0);
    bus.bar_req_i = 16'h0007; tick();
    check_eq("bar_partial", 32'(bus.bar_rel_o), 32'd0);
    bus.bar_req_i = 16'h000F; tick();
    check_eq("bar_fire", 32'(bus.bar_rel_o), 32'h000F);
    tick();
    check_eq("bar_single", 32'(bus.bar_rel_o), 32'd0);
    tick();
    check_eq("bar_held", 32'(bus.bar_rel_o), 32'd0);
    bus.bar_req_i = 16'h0000; tick();
    check_eq("bar_drop", 32'(bus.bar_rel_o), 32'd0);
    bus.bar_req_i = 16'h000F; tick();
    check_eq("bar_refire", 32'(bus.bar_rel_o), 32'h000F);
    bus.bar_req_i = '0;
    do_abort();

    // half-grid enabled, cluster of 8, PE5 done; inactive PE8 trap ignored
    start_run(16'h00FF, 5'd3, 16'd0);
    bus.trap_i = 16'h0120; tick();
    check_eq("cl_done_inact", 32'(bus.cl_done_o), 32'hFF00);
    bus.bar_req_i = 16'h00DF; tick();
    check_eq("bar_trapped", 32'(bus.bar_rel_o), 32'h00DF);
    tick();
    check_eq("bar_trapped_1c", 32'(bus.bar_rel_o), 32'd0);
    check_eq("no_finish_half", 32'(bus.finish_o), 32'd0);
    bus.trap_i = '0; bus.bar_req_i = '0;
    do_abort();

    // watchdog of 10 idle cycles
    start_run(16'hFFFF, 5'd2, 16'd10);
    repeat (10) tick();
    check_eq("wd_before", 32'(bus.state_o), 32'd1);
    tick();
    check_eq("wd_state", 32'(bus.state_o), 32'd3);
    check_eq("wd_error", 32'(bus.error_o), 32'd1);
    check_eq("wd_cycles", bus.run_cycles_o, 32'd11);
    check_eq("wd_cl_done", 32'(bus.cl_done_o), 32'd0);
    do_abort();
    check_eq("wd_abort_st", 32'(bus.state_o), 32'd0);
    check_eq("wd_abort_err", 32'(bus.error_o), 32'd0);

    // stall vector latency, abort priority, empty mask
    bus.mem_op_i = 16'h0003; bus.grant_i = 16'h0001; #1;
    check_eq("busy_pre", 32'(bus.busy_o), 32'h0003);
    tick();
    check_eq("busy_post", 32'(bus.busy_o), 32'h0002);
    bus.mem_op_i = '0; bus.grant_i = '0;
    bus.start_i = 1'b1; bus.abort_i = 1'b1; tick();
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    check_eq("start_abort", 32'(bus.state_o), 32'd0);
    start_run(16'h0000, 5'd2, 16'd0);
    check_eq("empty_done", 32'(bus.state_o), 32'd2);
    check_eq("empty_finish", 32'(bus.finish_o), 32'd1);
    do_abort();

    // async reset with a barrier about to fire
    start_run(16'hFFFF, 5'd2, 16'd0);
    bus.bar_req_i = 16'h0007; tick();
    bus.bar_req_i = 16'h000F;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_state", 32'(bus.state_o), 32'd0);
    check_eq("arst_rel", 32'(bus.bar_rel_o), 32'd0);
    check_eq("arst_cycles", bus.run_cycles_o, 32'd0);
    check_eq("arst_cl_done", 32'(bus.cl_done_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("arst_rel_a", 32'(bus.bar_rel_o), 32'd0);
    tick();
    check_eq("arst_rel_b", 32'(bus.bar_rel_o), 32'd0);
    check_eq("arst_idle", 32'(bus.state_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
